// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter that lets M masters share one interconnect port.
// Includes a bus watchdog that ends a stalled strobe by returning err to the granted master.
module wb_arbiter #(
  parameter int M       = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                clk_in,
  input  logic                reset_in,
  input  logic [M-1:0]        wb_cyc_in,
  input  logic [M-1:0]        wb_stb_in,
  input  logic [M-1:0]        wb_we_in,
  input  logic [M-1:0][3:0]   wb_sel_in,
  input  logic [M-1:0][31:0]  wb_addr_in,
  input  logic [M-1:0][31:0]  wb_wdata_in,
  output logic [M-1:0][31:0]  wb_rdata_in,
  output logic [M-1:0]        wb_ack_in,
  output logic [M-1:0]        wb_err_in,
  output logic                wb_cyc_out,
  output logic                wb_stb_out,
  output logic                wb_we_out,
  output logic [3:0]          wb_sel_out,
  output logic [31:0]         wb_addr_out,
  output logic [31:0]         wb_wdata_out,
  input  logic [31:0]         wb_rdata_out,
  input  logic                wb_ack_out,
  input  logic                wb_err_out
);

  localparam int GW   = $clog2(M);
  localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic             WD_EN   = (TIMEOUT > 0);
  localparam logic [WD_W-1:0]  WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          r_state;
  logic [GW-1:0]   r_grant;
  logic [GW-1:0]   r_rr_ptr;
  logic [WD_W-1:0] r_wd_cnt;

  logic          w_busy;
  logic          w_g_cyc;
  logic          w_g_stb;
  logic          w_route;
  logic          w_fire;
  logic          w_found;
  logic [GW-1:0] w_winner;
  logic [GW-1:0] w_next_ptr;

  assign w_busy     = (r_state == BUSY);
  assign w_g_cyc    = wb_cyc_in[r_grant];
  assign w_g_stb    = wb_stb_in[r_grant];
  assign w_route    = w_busy && w_g_cyc;
  assign w_next_ptr = (r_grant == GW'(M - 1)) ? '0 : r_grant + 1'b1;
  // A slave ack/err on the terminal cycle takes precedence over the watchdog.
  assign w_fire     = WD_EN && w_route && w_g_stb && !wb_ack_out && !wb_err_out &&
                      (r_wd_cnt == WD_LAST);

  always_comb begin
    w_found  = 1'b0;
    w_winner = r_rr_ptr;
    for (int i = 0; i < M; i++) begin
      if (!w_found && wb_cyc_in[(int'(r_rr_ptr) + i) % M]) begin
        w_found  = 1'b1;
        w_winner = GW'((int'(r_rr_ptr) + i) % M);
      end
    end
  end

  assign wb_cyc_out   = w_route && !w_fire;
  assign wb_stb_out   = w_route && w_g_stb && !w_fire;
  assign wb_we_out    = w_busy && wb_we_in[r_grant];
  assign wb_sel_out   = w_busy ? wb_sel_in[r_grant]   : 4'h0;
  assign wb_addr_out  = w_busy ? wb_addr_in[r_grant]  : 32'h0;
  assign wb_wdata_out = w_busy ? wb_wdata_in[r_grant] : 32'h0;

  // Responses reach only the granted master, and are dropped once it lets go of cyc.
  always_comb begin
    wb_ack_in   = '0;
    wb_err_in   = '0;
    wb_rdata_in = '0;
    for (int i = 0; i < M; i++) begin
      if (w_route && (r_grant == GW'(i))) begin
        wb_ack_in[i]   = wb_ack_out;
        wb_err_in[i]   = wb_err_out || w_fire;
        wb_rdata_in[i] = wb_rdata_out;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_wd_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wd_cnt <= '0;
          if (w_found) begin
            r_grant <= w_winner;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (!w_g_cyc) begin
            r_state  <= IDLE;
            r_rr_ptr <= w_next_ptr;
            r_wd_cnt <= '0;
          end else if (WD_EN && w_g_stb && !wb_ack_out && !wb_err_out && !w_fire) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end else begin
            r_wd_cnt <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with two masters and a short watchdog.
// Inputs change 1 ns after the rising edge; outputs are sampled 2 ns later.
module tb_wb_arbiter;

  logic              clk_in = 1'b0;
  logic              reset_in;
  logic [1:0]        wb_cyc_in, wb_stb_in, wb_we_in;
  logic [1:0][3:0]   wb_sel_in;
  logic [1:0][31:0]  wb_addr_in, wb_wdata_in;
  logic [1:0][31:0]  wb_rdata_in;
  logic [1:0]        wb_ack_in, wb_err_in;
  logic              wb_cyc_out, wb_stb_out, wb_we_out;
  logic [3:0]        wb_sel_out;
  logic [31:0]       wb_addr_out, wb_wdata_out;
  logic [31:0]       wb_rdata_out;
  logic              wb_ack_out, wb_err_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  wb_arbiter #(.M(2), .TIMEOUT(4)) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .wb_cyc_in(wb_cyc_in), .wb_stb_in(wb_stb_in), .wb_we_in(wb_we_in),
    .wb_sel_in(wb_sel_in), .wb_addr_in(wb_addr_in), .wb_wdata_in(wb_wdata_in),
    .wb_rdata_in(wb_rdata_in), .wb_ack_in(wb_ack_in), .wb_err_in(wb_err_in),
    .wb_cyc_out(wb_cyc_out), .wb_stb_out(wb_stb_out), .wb_we_out(wb_we_out),
    .wb_sel_out(wb_sel_out), .wb_addr_out(wb_addr_out), .wb_wdata_out(wb_wdata_out),
    .wb_rdata_out(wb_rdata_out), .wb_ack_out(wb_ack_out), .wb_err_out(wb_err_out)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_inputs();
    wb_cyc_in = '0; wb_stb_in = '0; wb_we_in = '0; wb_sel_in = '0;
    wb_addr_in = '0; wb_wdata_in = '0;
    wb_rdata_out = '0; wb_ack_out = 1'b0; wb_err_out = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset_in = 1'b1;
    step();
    step();
    reset_in = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_in = 1'b1;
    wb_cyc_in = 2'b11; wb_stb_in = 2'b11; wb_we_in = 2'b11;
    wb_sel_in[0] = 4'hF; wb_addr_in[0] = 32'h1111_0000; wb_wdata_in[0] = 32'h2222_0000;
    wb_ack_out = 1'b1; wb_err_out = 1'b1; wb_rdata_out = 32'h1234_5678;
    step();
    #2;
    checks++; if (wb_cyc_out !== 1'b0) begin errors++; $display("FAIL reset_cyc_out got %b exp 0", wb_cyc_out); end
    checks++; if (wb_stb_out !== 1'b0) begin errors++; $display("FAIL reset_stb_out got %b exp 0", wb_stb_out); end
    checks++; if (wb_we_out !== 1'b0) begin errors++; $display("FAIL reset_we_out got %b exp 0", wb_we_out); end
    checks++; if (wb_sel_out !== 4'h0) begin errors++; $display("FAIL reset_sel_out got %h exp 0", wb_sel_out); end
    checks++; if (wb_addr_out !== 32'h0) begin errors++; $display("FAIL reset_addr_out got %h exp 0", wb_addr_out); end
    checks++; if (wb_wdata_out !== 32'h0) begin errors++; $display("FAIL reset_wdata_out got %h exp 0", wb_wdata_out); end
    checks++; if (wb_ack_in !== 2'b00) begin errors++; $display("FAIL reset_ack_in got %b exp 00", wb_ack_in); end
    checks++; if (wb_err_in !== 2'b00) begin errors++; $display("FAIL reset_err_in got %b exp 00", wb_err_in); end
    checks++; if (wb_rdata_in !== 64'h0) begin errors++; $display("FAIL reset_rdata_in got %h exp 0", wb_rdata_in); end
    apply_reset();
  endtask

  task automatic test_single_read();
    apply_reset();
    wb_cyc_in = 2'b01; wb_stb_in = 2'b01; wb_sel_in[0] = 4'hF; wb_addr_in[0] = 32'h0000_3000;
    #2;
    checks++; if (wb_cyc_out !== 1'b0) begin errors++; $display("FAIL read_latency_cyc got %b exp 0", wb_cyc_out); end
    step();
    #2;
    checks++; if (wb_cyc_out !== 1'b1 || wb_stb_out !== 1'b1) begin errors++; $display("FAIL read_fwd_cyc_stb got %b%b exp 11", wb_cyc_out, wb_stb_out); end
    checks++; if (wb_addr_out !== 32'h0000_3000) begin errors++; $display("FAIL read_fwd_addr got %h exp 00003000", wb_addr_out); end
    checks++; if (wb_we_out !== 1'b0 || wb_sel_out !== 4'hF) begin errors++; $display("FAIL read_fwd_we_sel got %b %h exp 0 f", wb_we_out, wb_sel_out); end
    checks++; if (wb_ack_in !== 2'b00) begin errors++; $display("FAIL read_early_ack got %b exp 00", wb_ack_in); end
    step();
    wb_ack_out = 1'b1; wb_rdata_out = 32'hDEAD_BEEF;
    #2;
    checks++; if (wb_ack_in !== 2'b01) begin errors++; $display("FAIL read_ack_route got %b exp 01", wb_ack_in); end
    checks++; if (wb_rdata_in[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_rdata_m0 got %h exp deadbeef", wb_rdata_in[0]); end
    checks++; if (wb_rdata_in[1] !== 32'h0) begin errors++; $display("FAIL read_rdata_m1 got %h exp 0", wb_rdata_in[1]); end
    step();
    wb_cyc_in = 2'b00; wb_stb_in = 2'b00; wb_ack_out = 1'b0; wb_rdata_out = 32'h0;
    #2;
    checks++; if (wb_cyc_out !== 1'b0 || wb_stb_out !== 1'b0) begin errors++; $display("FAIL read_release got %b%b exp 00", wb_cyc_out, wb_stb_out); end
    step();
  endtask

  task automatic test_round_robin();
    apply_reset();
    wb_cyc_in = 2'b11; wb_stb_in = 2'b11;
    wb_addr_in[0] = 32'h0000_0100; wb_addr_in[1] = 32'h0000_0200;
    #2;
    checks++; if (wb_cyc_out !== 1'b0) begin errors++; $display("FAIL rr_idle0 got %b exp 0", wb_cyc_out); end
    step();
    wb_ack_out = 1'b1;
    #2;
    checks++; if (wb_addr_out !== 32'h0000_0100) begin errors++; $display("FAIL rr_first_m0 got %h exp 00000100", wb_addr_out); end
    checks++; if (wb_ack_in !== 2'b01) begin errors++; $display("FAIL rr_ack_m0 got %b exp 01", wb_ack_in); end
    step();
    wb_cyc_in = 2'b10; wb_stb_in = 2'b10; wb_ack_out = 1'b0;
    #2;
    checks++; if (wb_cyc_out !== 1'b0 || wb_stb_out !== 1'b0) begin errors++; $display("FAIL rr_release_m0 got %b%b exp 00", wb_cyc_out, wb_stb_out); end
    step();
    wb_cyc_in = 2'b11; wb_stb_in = 2'b11;
    #2;
    checks++; if (wb_cyc_out !== 1'b0) begin errors++; $display("FAIL rr_gap_idle got %b exp 0", wb_cyc_out); end
    step();
    #2;
    checks++; if (wb_cyc_out !== 1'b1 || wb_addr_out !== 32'h0000_0200) begin errors++; $display("FAIL rr_second_m1 got %b %h exp 1 00000200", wb_cyc_out, wb_addr_out); end
    wb_ack_out = 1'b1;
    #1;
    checks++; if (wb_ack_in !== 2'b10) begin errors++; $display("FAIL rr_ack_m1 got %b exp 10", wb_ack_in); end
    step();
    wb_cyc_in = 2'b01; wb_stb_in = 2'b01; wb_ack_out = 1'b0;
    step();
    #2;
    checks++; if (wb_cyc_out !== 1'b0) begin errors++; $display("FAIL rr_gap2_idle got %b exp 0", wb_cyc_out); end
    step();
    #2;
    checks++; if (wb_addr_out !== 32'h0000_0100) begin errors++; $display("FAIL rr_third_m0 got %h exp 00000100", wb_addr_out); end
    clear_inputs();
    step();
    step();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    wb_cyc_in = 2'b10; wb_stb_in = 2'b10; wb_we_in = 2'b10;
    wb_addr_in[1] = 32'h0000_4000; wb_sel_in[1] = 4'hF; wb_wdata_in[1] = 32'h0000_0005;
    wb_addr_in[0] = 32'h0000_3000; wb_sel_in[0] = 4'h3;
    step();
    wb_cyc_in = 2'b11; wb_stb_in = 2'b11;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step();
      wb_ack_out = 1'b1;
      #2;
      checks++; if (wb_addr_out !== 32'h0000_4000 || wb_wdata_out !== 32'h5) begin errors++; $display("FAIL b2b_fwd_%0d got %h %h exp 00004000 00000005", k, wb_addr_out, wb_wdata_out); end
      checks++; if (wb_we_out !== 1'b1 || wb_sel_out !== 4'hF) begin errors++; $display("FAIL b2b_we_sel_%0d got %b %h exp 1 f", k, wb_we_out, wb_sel_out); end
      checks++; if (wb_ack_in !== 2'b10) begin errors++; $display("FAIL b2b_ack_%0d got %b exp 10", k, wb_ack_in); end
    end
    step();
    wb_cyc_in = 2'b01; wb_stb_in = 2'b01; wb_we_in = 2'b00; wb_ack_out = 1'b0;
    #2;
    checks++; if (wb_cyc_out !== 1'b0 || wb_ack_in !== 2'b00) begin errors++; $display("FAIL b2b_release got %b %b exp 0 00", wb_cyc_out, wb_ack_in); end
    step();
    #2;
    checks++; if (wb_cyc_out !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", wb_cyc_out); end
    step();
    #2;
    checks++; if (wb_addr_out !== 32'h0000_3000 || wb_cyc_out !== 1'b1) begin errors++; $display("FAIL b2b_m0_grant got %h %b exp 00003000 1", wb_addr_out, wb_cyc_out); end
    clear_inputs();
    step();
    step();
  endtask

  task automatic test_watchdog();
    apply_reset();
    wb_cyc_in = 2'b01; wb_stb_in = 2'b01; wb_addr_in[0] = 32'h0000_BAD0;
    for (int c = 1; c <= 4; c++) begin
      step();
      #2;
      if (c < 4) begin
        checks++; if (wb_err_in !== 2'b00 || wb_stb_out !== 1'b1) begin errors++; $display("FAIL wd_wait_%0d got err %b stb %b exp 00 1", c, wb_err_in, wb_stb_out); end
      end else begin
        checks++; if (wb_err_in !== 2'b01) begin errors++; $display("FAIL wd_fire_err got %b exp 01", wb_err_in); end
        checks++; if (wb_stb_out !== 1'b0 || wb_cyc_out !== 1'b0) begin errors++; $display("FAIL wd_fire_bus got %b%b exp 00", wb_cyc_out, wb_stb_out); end
      end
    end
    step();
    #2;
    checks++; if (wb_err_in !== 2'b00 || wb_stb_out !== 1'b1) begin errors++; $display("FAIL wd_restart got err %b stb %b exp 00 1", wb_err_in, wb_stb_out); end
    clear_inputs();
    step();
    step();
  endtask

  task automatic test_ack_on_timeout();
    apply_reset();
    wb_cyc_in = 2'b01; wb_stb_in = 2'b01; wb_addr_in[0] = 32'h0000_5000;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 4) begin
        wb_ack_out = 1'b1; wb_rdata_out = 32'h0000_00A5;
      end
    end
    #2;
    checks++; if (wb_ack_in !== 2'b01 || wb_rdata_in[0] !== 32'hA5) begin errors++; $display("FAIL wdack_ack got %b %h exp 01 000000a5", wb_ack_in, wb_rdata_in[0]); end
    checks++; if (wb_err_in !== 2'b00) begin errors++; $display("FAIL wdack_err got %b exp 00", wb_err_in); end
    checks++; if (wb_stb_out !== 1'b1) begin errors++; $display("FAIL wdack_stb got %b exp 1", wb_stb_out); end
    clear_inputs();
    step();
    step();
  endtask

  task automatic test_reset_mid_transfer();
    apply_reset();
    wb_cyc_in = 2'b01; wb_stb_in = 2'b01;
    wb_addr_in[0] = 32'h0000_0010; wb_addr_in[1] = 32'h0000_0020;
    step();
    wb_cyc_in = 2'b00; wb_stb_in = 2'b00;
    step();
    wb_cyc_in = 2'b01; wb_stb_in = 2'b01;
    step();
    #2;
    checks++; if (wb_cyc_out !== 1'b1 || wb_stb_out !== 1'b1) begin errors++; $display("FAIL rst_mid_busy got %b%b exp 11", wb_cyc_out, wb_stb_out); end
    reset_in = 1'b1;
    step();
    reset_in = 1'b0;
    wb_cyc_in = 2'b11; wb_stb_in = 2'b11;
    #2;
    checks++; if (wb_cyc_out !== 1'b0 || wb_stb_out !== 1'b0 || wb_addr_out !== 32'h0) begin errors++; $display("FAIL rst_mid_outputs got %b%b %h exp 00 0", wb_cyc_out, wb_stb_out, wb_addr_out); end
    checks++; if (wb_ack_in !== 2'b00 || wb_err_in !== 2'b00) begin errors++; $display("FAIL rst_mid_resp got %b %b exp 00 00", wb_ack_in, wb_err_in); end
    step();
    #2;
    checks++; if (wb_addr_out !== 32'h0000_0010) begin errors++; $display("FAIL rst_mid_rrptr got %h exp 00000010", wb_addr_out); end
    clear_inputs();
    step();
    step();
  endtask

  initial begin
    clear_inputs();
    reset_in = 1'b1;
    test_reset();
    test_single_read();
    test_round_robin();
    test_back_to_back();
    test_watchdog();
    test_ack_on_timeout();
    test_reset_mid_transfer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
